// File: rtl/present_core_pio_edge_in_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : present_core_pio_edge_in_if                                   |
// | Desc     : Avalon-MM slave bus bundle for the edge-capturing input PIO.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface present_core_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/present_core_pio_edge_in.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : present_core_pio_edge_in                                      |
// | Desc     : Input PIO with synchroniser, sticky W1C edge capture and a    |
// |            maskable level interrupt on an Avalon-MM slave.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module present_core_pio_edge_in #(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic [WIDTH-1:0]   in_port,
  present_core_pio_edge_in_if.slave bus
);

  localparam logic [1:0] c_ADDR_DATA   = 2'd0;
  localparam logic [1:0] c_ADDR_RSVD   = 2'd1;
  localparam logic [1:0] c_ADDR_MASK   = 2'd2;
  localparam logic [1:0] c_ADDR_EDGE   = 2'd3;
  localparam int         c_CNT_W       = $clog2(SYNC_STAGES + 2);
  localparam logic [c_CNT_W-1:0] c_PRIME_MAX = c_CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_irqmask;
  logic [WIDTH-1:0]   r_edgecap;
  logic [31:0]        r_readdata;
  logic [c_CNT_W-1:0] r_prime_cnt;

  logic [WIDTH-1:0]   w_data_in;
  logic [WIDTH-1:0]   w_edge;
  logic [WIDTH-1:0]   w_set;
  logic [WIDTH-1:0]   w_clr;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_primed;
  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_data_ext;
  logic [31:0]        w_mask_ext;
  logic [31:0]        w_edge_ext;
  logic [31:0]        w_rd_mux;

  assign w_data_in = r_sync[SYNC_STAGES-1];
  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_rd      = bus.chipselect & ~bus.read_n;
  assign w_wdata   = bus.writedata[WIDTH-1:0];
  assign w_primed  = (r_prime_cnt == c_PRIME_MAX);

  generate
    if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge = ~w_data_in & r_prev;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign w_edge = w_data_in ^ r_prev;
    end else begin : g_rise
      assign w_edge = w_data_in & ~r_prev;
    end
  endgenerate

  // Suppress detection until the chain and prev hold real samples, so a
  // pin that is high out of reset does not look like a rising edge.
  assign w_set = w_primed ? w_edge : '0;
  assign w_clr = (w_wr && (bus.address == c_ADDR_EDGE)) ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prime_cnt <= '0;
    end else if (!w_primed) begin
      r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr && (bus.address == c_ADDR_MASK)) begin
      r_irqmask <= w_wdata;
    end
  end

  // Set is OR'd in after the clear so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_set;
    end
  end

  generate
    if (WIDTH == 32) begin : g_full
      assign w_data_ext = w_data_in;
      assign w_mask_ext = r_irqmask;
      assign w_edge_ext = r_edgecap;
    end else begin : g_pad
      assign w_data_ext = {{(32-WIDTH){1'b0}}, w_data_in};
      assign w_mask_ext = {{(32-WIDTH){1'b0}}, r_irqmask};
      assign w_edge_ext = {{(32-WIDTH){1'b0}}, r_edgecap};
    end
  endgenerate

  always_comb begin
    w_rd_mux = 32'h0;
    case (bus.address)
      c_ADDR_DATA: w_rd_mux = w_data_ext;
      c_ADDR_RSVD: w_rd_mux = 32'h0;
      c_ADDR_MASK: w_rd_mux = w_mask_ext;
      c_ADDR_EDGE: w_rd_mux = w_edge_ext;
      default:     w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'h0;
    end else begin
      r_readdata <= w_rd ? w_rd_mux : 32'h0;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_present_core_pio_edge_in.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_present_core_pio_edge_in                                   |
// | Desc     : Self-checking bench; two DUT flavours share one stimulus.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_present_core_pio_edge_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_port = 32'h0;
  logic [1:0]  address = 2'd0;
  logic        cs = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [31:0] wdata = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  present_core_pio_edge_in_if bus0();
  present_core_pio_edge_in_if bus2();

  assign bus0.address = address;  assign bus2.address = address;
  assign bus0.chipselect = cs;    assign bus2.chipselect = cs;
  assign bus0.read_n = rd_n;      assign bus2.read_n = rd_n;
  assign bus0.write_n = wr_n;     assign bus2.write_n = wr_n;
  assign bus0.writedata = wdata;  assign bus2.writedata = wdata;

  // dut0: 32-bit rising edge, 2 stages; dut2: 16-bit any edge, 3 stages
  present_core_pio_edge_in #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0.slave));
  present_core_pio_edge_in #(.WIDTH(16), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port[15:0]), .bus(bus2.slave));

  // Reference model: data_in is the input sample taken S edges ago
  int          ms[2] = '{2, 3};
  int          met[2] = '{0, 2};
  logic [31:0] mwm[2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] hist[$];
  logic [31:0] m_ec[2];
  logic [31:0] m_mask[2];
  logic [31:0] exp_rd[2];
  logic        exp_irq[2];

  function automatic logic [31:0] dval(int k, int n);
    if (n < ms[k]) return 32'h0;
    return hist[n - ms[k]] & mwm[k];
  endfunction

  function automatic logic [31:0] get_rd(int k);
    return (k == 0) ? bus0.readdata : bus2.readdata;
  endfunction

  function automatic logic get_irq(int k);
    return (k == 0) ? bus0.irq : bus2.irq;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      m_ec[k] = 0; m_mask[k] = 0; exp_rd[k] = 0; exp_irq[k] = 0;
    end
  endtask

  task automatic tick();
    int n;
    logic [31:0] cur, prv, edg, clr;
    @(posedge clk);
    if (reset_n) begin
      hist.push_back(in_port);
      n = hist.size();
      for (int k = 0; k < 2; k++) begin
        cur = dval(k, n - 1);
        prv = dval(k, n - 2);
        edg = (met[k] == 0) ? (cur & ~prv) : (met[k] == 1) ? (~cur & prv) : (cur ^ prv);
        if ((n - 1) < ms[k] + 1) edg = 0;
        exp_rd[k] = 0;
        if (cs && !rd_n)
          case (address)
            2'd0: exp_rd[k] = cur;
            2'd2: exp_rd[k] = m_mask[k];
            2'd3: exp_rd[k] = m_ec[k];
            default: exp_rd[k] = 0;
          endcase
        clr = (cs && !wr_n && address == 2'd3) ? (wdata & mwm[k]) : 0;
        if (cs && !wr_n && address == 2'd2) m_mask[k] = wdata & mwm[k];
        m_ec[k] = (m_ec[k] & ~clr) | edg;
        exp_irq[k] = |(m_ec[k] & m_mask[k]);
      end
    end
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
    tick();
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] a);
    address = a; cs = 1'b1; rd_n = 1'b0;
    tick();
    cs = 1'b0; rd_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 32'h0000_0001;
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_irq(k) !== 1'b0) begin
        failures++; $display("FAIL reset_irq dut%0d got=%b exp=0", k, get_irq(k));
      end
    end
    do_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'h0) begin
        failures++; $display("FAIL reset_edgecap dut%0d got=%h exp=0", k, get_rd(k));
      end
    end
    do_read(2'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'h1) begin
        failures++; $display("FAIL reset_data dut%0d got=%h exp=1", k, get_rd(k));
      end
    end
  endtask

  task automatic test_rise_irq();
    do_write(2'd2, 32'h1);
    in_port = 32'h0;
    repeat (6) tick();
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h1;
    tick();
    checks++;
    if (bus0.irq !== 1'b0) begin failures++; $display("FAIL rise_t0 got=%b exp=0", bus0.irq); end
    tick();
    checks++;
    if (bus0.irq !== 1'b0) begin failures++; $display("FAIL rise_t1 got=%b exp=0", bus0.irq); end
    tick();
    checks++;
    if (bus0.irq !== 1'b1) begin failures++; $display("FAIL rise_t2 got=%b exp=1", bus0.irq); end
    checks++;
    if (bus2.irq !== exp_irq[1]) begin
      failures++; $display("FAIL rise_any_t2 got=%b exp=%b", bus2.irq, exp_irq[1]);
    end
    do_read(2'd3);
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++; $display("FAIL rise_edgecap got=%h exp=1", bus0.readdata);
    end
    do_write(2'd3, 32'h1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_irq(k) !== 1'b0) begin
        failures++; $display("FAIL w1c_irq dut%0d got=%b exp=0", k, get_irq(k));
      end
    end
  endtask

  task automatic test_set_wins();
    in_port = 32'h0;
    repeat (6) tick();
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h1;
    tick();
    tick();
    do_write(2'd3, 32'h1);
    checks++;
    if (bus0.irq !== 1'b1) begin failures++; $display("FAIL setwins_irq got=%b exp=1", bus0.irq); end
    do_read(2'd3);
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++; $display("FAIL setwins_edgecap got=%h exp=1", bus0.readdata);
    end
    checks++;
    if (bus2.readdata !== exp_rd[1]) begin
      failures++; $display("FAIL setwins_edgecap_any got=%h exp=%h", bus2.readdata, exp_rd[1]);
    end
  endtask

  task automatic test_any_edge();
    do_write(2'd2, 32'h0);
    in_port = 32'h0;
    repeat (6) tick();
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h20;
    repeat (6) tick();
    in_port = 32'h0;
    repeat (6) tick();
    do_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'h20) begin
        failures++; $display("FAIL any_edgecap dut%0d got=%h exp=00000020", k, get_rd(k));
      end
      checks++;
      if (get_irq(k) !== 1'b0) begin
        failures++; $display("FAIL any_masked_irq dut%0d got=%b exp=0", k, get_irq(k));
      end
    end
    do_write(2'd2, 32'h20);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_irq(k) !== 1'b1) begin
        failures++; $display("FAIL any_unmasked_irq dut%0d got=%b exp=1", k, get_irq(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0[4];
    logic [31:0] e2[4];
    do_write(2'd2, 32'h1234_5678);
    in_port = 32'hA5A5_0000;
    repeat (6) tick();
    e0[0] = 32'hA5A5_0000; e0[1] = 32'h0; e0[2] = 32'h1234_5678;
    e2[0] = 32'h0;         e2[1] = 32'h0; e2[2] = 32'h0000_5678;
    cs = 1'b1; rd_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      if (a == 3) begin e0[3] = exp_rd[0]; e2[3] = exp_rd[1]; end
      checks++;
      if (bus0.readdata !== e0[a]) begin
        failures++; $display("FAIL b2b_rd addr%0d dut0 got=%h exp=%h", a, bus0.readdata, e0[a]);
      end
      checks++;
      if (bus2.readdata !== e2[a]) begin
        failures++; $display("FAIL b2b_rd addr%0d dut2 got=%h exp=%h", a, bus2.readdata, e2[a]);
      end
    end
    cs = 1'b0; rd_n = 1'b1;
    tick();
    checks++;
    if (bus0.readdata !== 32'h0) begin
      failures++; $display("FAIL idle_readdata got=%h exp=0", bus0.readdata);
    end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ $urandom();
      op = $urandom_range(5);
      address = 2'($urandom_range(3));
      wdata = $urandom();
      cs   = (op != 5);
      rd_n = !(op == 1 || op == 3 || op == 5);
      wr_n = !(op == 2 || op == 3);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_rd(k) !== exp_rd[k]) begin
          failures++; $display("FAIL rand_rd cyc%0d dut%0d got=%h exp=%h", i, k, get_rd(k), exp_rd[k]);
        end
        checks++;
        if (get_irq(k) !== exp_irq[k]) begin
          failures++; $display("FAIL rand_irq cyc%0d dut%0d got=%b exp=%b", i, k, get_irq(k), exp_irq[k]);
        end
      end
    end
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_write(2'd2, 32'hFF);
    in_port = 32'h0;
    repeat (6) tick();
    do_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'hFF;
    repeat (8) tick();
    do_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'hFF) begin
        failures++; $display("FAIL pre_reset_edgecap dut%0d got=%h exp=000000ff", k, get_rd(k));
      end
    end
    #3;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'h0) begin
        failures++; $display("FAIL async_readdata dut%0d got=%h exp=0", k, get_rd(k));
      end
      checks++;
      if (get_irq(k) !== 1'b0) begin
        failures++; $display("FAIL async_irq dut%0d got=%b exp=0", k, get_irq(k));
      end
    end
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    do_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'h0) begin
        failures++; $display("FAIL post_reset_edgecap dut%0d got=%h exp=0", k, get_rd(k));
      end
      checks++;
      if (get_irq(k) !== 1'b0) begin
        failures++; $display("FAIL post_reset_irq dut%0d got=%b exp=0", k, get_irq(k));
      end
    end
    do_read(2'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_rd(k) !== 32'hFF) begin
        failures++; $display("FAIL post_reset_data dut%0d got=%h exp=000000ff", k, get_rd(k));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rise_irq();
    test_set_wins();
    test_any_edge();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
